// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral responders: register offsets,
// event counter width and the default synchroniser width.
package periph_pkg;

   localparam logic [7:0] IN_SW_OFS   = 8'h00;
   localparam logic [7:0] IN_BTN_OFS  = 8'h10;
   localparam logic [7:0] IN_EDGE_OFS = 8'h14;
   localparam logic [7:0] IN_CNT_OFS  = 8'h18;

   localparam int IN_CNT_W = 16;
   localparam int SYNC2_W  = 32;

endpackage

// File: rtl/btn_debounce.sv
// Single-button filter: the stable level follows the synchronised input only after
// DEB_CYCLES consecutive cycles of disagreement; any agreement restarts the count.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (din == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level <= din;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/in_periph.sv
// Input-peripheral responder for the 0x9xx region: switch/button sync, optional
// debounce (enabled by defining IN_PERIPH_DEBOUNCE_EN), press events and read mux.
module in_periph
   import periph_pkg::*;
#(
   parameter int NBTN       = 4,
   parameter int DEB_CYCLES = 500000,
   parameter bit BTN_INV    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   input  logic        wren,
   input  logic [31:0] sw,
   input  logic [31:0] btn,
   output logic [31:0] rdata
);

   logic [SYNC2_W-1:0]  sw_p0, sw_p1;
   logic [NBTN-1:0]     btn_p0, btn_p1;
   logic [NBTN-1:0]     btn_sync, stable, stable_prev, rise, edge_q, edge_clr;
   logic [IN_CNT_W-1:0] cnt_q;
   logic [5:0]          rise_cnt;
   logic                cnt_wr;
   logic                unused_bits;

   function automatic logic [5:0] popcnt(input logic [NBTN-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < NBTN; i++) c = c + {5'b0, v[i]};
      return c;
   endfunction

   function automatic logic [IN_CNT_W-1:0] sat_add(input logic [IN_CNT_W-1:0] a,
                                                   input logic [5:0] b);
      logic [IN_CNT_W:0] s;
      s = {1'b0, a} + {{(IN_CNT_W - 5){1'b0}}, b};
      return s[IN_CNT_W] ? '1 : s[IN_CNT_W-1:0];
   endfunction

   // Two-flop synchronisers
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_p0  <= '0;
         sw_p1  <= '0;
         btn_p0 <= '0;
         btn_p1 <= '0;
      end else begin
         sw_p0  <= sw;
         sw_p1  <= sw_p0;
         btn_p0 <= btn[NBTN-1:0];
         btn_p1 <= btn_p0;
      end
   end

   assign btn_sync = BTN_INV ? ~btn_p1 : btn_p1;

`ifdef IN_PERIPH_DEBOUNCE_EN
   for (genvar i = 0; i < NBTN; i++) begin : g_deb
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .din   (btn_sync[i]),
         .level (stable[i])
      );
   end
`else
   assign stable = btn_sync;
`endif

   // Edge detect and sticky event registers; a same-cycle rise beats a clear
   assign rise     = stable & ~stable_prev;
   assign rise_cnt = popcnt(rise);
   assign edge_clr = (wren && addr == IN_EDGE_OFS) ? wdata[NBTN-1:0] : '0;
   assign cnt_wr   = wren && addr == IN_CNT_OFS;

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_prev <= '0;
         edge_q      <= '0;
         cnt_q       <= '0;
      end else begin
         stable_prev <= stable;
         edge_q      <= (edge_q & ~edge_clr) | rise;
         cnt_q       <= cnt_wr ? {{(IN_CNT_W - 6){1'b0}}, rise_cnt} : sat_add(cnt_q, rise_cnt);
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         IN_SW_OFS:   rdata = sw_p1;
         IN_BTN_OFS:  rdata[NBTN-1:0] = stable;
         IN_EDGE_OFS: rdata[NBTN-1:0] = edge_q;
         IN_CNT_OFS:  rdata[IN_CNT_W-1:0] = cnt_q;
         default:     rdata = '0;
      endcase
   end

   assign unused_bits = ^{btn, wdata};

endmodule

// File: tb/tb_in_periph.sv
// Randomised bench for in_periph against a cycle-level behavioural model; covers
// both builds, with and without IN_PERIPH_DEBOUNCE_EN.
module tb_in_periph;

   localparam int NBTN = 4;
   localparam int DEB  = 4;
`ifdef IN_PERIPH_DEBOUNCE_EN
   localparam int BTN_LAT = DEB + 2;
   localparam int BOUNCE_INC = 1;
`else
   localparam int BTN_LAT = 2;
   localparam int BOUNCE_INC = 2;
`endif

   logic        clk = 1'b0;
   logic        rst, wren;
   logic [7:0]  addr;
   logic [31:0] wdata, sw, btn, rdata;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: raw inputs delayed two edges, filtered level, events.
   logic [31:0] m_sw_pend, m_sw_vis;
   logic [3:0]  m_btn_pend, m_btn_sync, m_stable, m_prev, m_edge;
   int          m_run[4];
   int          m_cnt;

   always #5 clk = ~clk;

   in_periph #(.NBTN(NBTN), .DEB_CYCLES(DEB), .BTN_INV(1'b0)) dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .wdata (wdata),
      .wren  (wren),
      .sw    (sw),
      .btn   (btn),
      .rdata (rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] vis_btn();
`ifdef IN_PERIPH_DEBOUNCE_EN
      return m_stable;
`else
      return m_btn_sync;
`endif
   endfunction

   function automatic logic [3:0] m_rise();
      return vis_btn() & ~m_prev;
   endfunction

   function automatic logic [31:0] exp_read(input logic [7:0] a);
      case (a)
         8'h00:   return m_sw_vis;
         8'h10:   return {28'b0, vis_btn()};
         8'h14:   return {28'b0, m_edge};
         8'h18:   return m_cnt;
         default: return 32'h0;
      endcase
   endfunction

   task automatic check_reads();
      logic [7:0] ofs[5];
      ofs = '{8'h00, 8'h10, 8'h14, 8'h18, 8'h20};
      wren = 1'b0;
      foreach (ofs[i]) begin
         addr = ofs[i];
         #1;
         check($sformatf("rd%02h", ofs[i]), rdata, exp_read(ofs[i]));
      end
   endtask

   // One clock: derive next model state from current inputs, advance, compare.
   task automatic tick();
      logic [3:0]  r, n_edge, n_stable, n_prev, clr;
      logic [31:0] raw_sw;
      logic [3:0]  raw_btn;
      int          n_cnt, pc;
      int          n_run[4];
      r = m_rise();
      raw_sw = sw;
      raw_btn = btn[3:0];
      n_prev = vis_btn();
      n_stable = m_stable;
      n_run = m_run;
      clr = (wren && addr == 8'h14) ? wdata[3:0] : 4'h0;
      n_edge = (m_edge & ~clr) | r;
      pc = $countones(r);
      if (wren && addr == 8'h18) n_cnt = pc;
      else n_cnt = (m_cnt + pc > 65535) ? 65535 : m_cnt + pc;
      for (int i = 0; i < 4; i++) begin
         if (m_btn_sync[i] != m_stable[i]) begin
            n_run[i] = m_run[i] + 1;
            if (n_run[i] == DEB) begin
               n_stable[i] = m_btn_sync[i];
               n_run[i] = 0;
            end
         end else begin
            n_run[i] = 0;
         end
      end
      @(posedge clk);
      if (rst) begin
         m_sw_pend = '0; m_sw_vis = '0; m_btn_pend = '0; m_btn_sync = '0;
         m_stable = '0; m_prev = '0; m_edge = '0; m_cnt = 0;
         m_run = '{0, 0, 0, 0};
      end else begin
         m_sw_vis = m_sw_pend;
         m_sw_pend = raw_sw;
         m_btn_sync = m_btn_pend;
         m_btn_pend = raw_btn;
         m_stable = n_stable;
         m_run = n_run;
         m_prev = n_prev;
         m_edge = n_edge;
         m_cnt = n_cnt;
      end
      #1;
      check_reads();
   endtask

   initial begin
      int  c0;
      bit  hit;
      logic [7:0] wofs[6];
      wofs = '{8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h04};

      rst = 1'b1; wren = 1'b0; addr = 8'h00; wdata = '0;
      sw = 32'hFFFF_FFFF; btn = 32'h0000_000F;
      repeat (3) tick();

      rst = 1'b0; sw = 32'h0000_A5A5; btn = '0;
      tick();
      tick();
      addr = 8'h00; #1; check("sw_lat", rdata, 32'h0000_A5A5);
      addr = 8'h20; #1; check("unmapped", rdata, 32'h0);

      btn = 32'h4;
      for (int t = 1; t <= BTN_LAT; t++) begin
         tick();
         addr = 8'h10; #1;
         check("btn_lat", rdata, (t == BTN_LAT) ? 32'h4 : 32'h0);
      end
      tick();
      addr = 8'h14; #1; check("press_edge", rdata, 32'h4);
      addr = 8'h18; #1; check("press_cnt", rdata, 32'h1);

      c0 = 1;
      btn = 32'h5; tick();
      btn = 32'h5; tick();
      btn = 32'h4; tick();
      btn = 32'h5;
      repeat (DEB + 4) tick();
      addr = 8'h18; #1; check("bounce_cnt", rdata, c0 + BOUNCE_INC);

      btn = 32'h1;
      repeat (DEB + 4) tick();
      wren = 1'b1; addr = 8'h14; wdata = 32'hF;
      tick();
      addr = 8'h14; #1; check("clr_all", rdata, 32'h0);

      btn = 32'h5;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (m_rise()[2]) begin
            hit = 1'b1;
            wren = 1'b1; addr = 8'h14; wdata = 32'h4;
         end
         tick();
      end
      check("race_seen", {31'b0, hit}, 32'h1);
      addr = 8'h14; #1; check("race_set_wins", rdata, 32'h4);
      wren = 1'b1; addr = 8'h14; wdata = 32'h4;
      tick();
      addr = 8'h14; #1; check("clr_no_rise", rdata, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         sw = $urandom;
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0)
            btn = {$urandom_range(0, 32'hFFFF), 12'h0, btn[3:0] ^ (4'h1 << $urandom_range(0, 3))};
         if ($urandom_range(0, 5) == 0) begin
            wren = 1'b1;
            addr = wofs[$urandom_range(0, 5)];
            wdata = $urandom;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/in_periph.md
# in_periph

Memory-mapped input-peripheral responder for the 0x9xx region of the load/store unit's address map. It synchronises the raw switch and button inputs and, when enabled, debounces the buttons. It captures button press events in a sticky write-1-to-clear register and returns the addressed register on `rdata` for the load/store unit's byte/half/word extraction. It replaces the purely combinational switch/button mux at that address range.

## Interface
Parameters:
- `NBTN`, 4: number of implemented buttons (1–32); `btn[31:NBTN]` is ignored and reads as 0.
- `DEB_CYCLES`, 500000: consecutive stable cycles required before the debounced button level changes (≥2).
- `BTN_INV`, 0: when 1, raw buttons are active-low and are inverted after synchronisation.

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `addr`, input, 8: byte offset within the input region, i.e. the load/store unit's `addr[7:0]`.
- `wdata`, input, 32: store data, already merged for byte and half-word stores.
- `wren`, input, 1: store strobe, qualified by the parent with region select (`addr[11:8]==4'b1001`).
- `sw`, input, 32: raw asynchronous switch inputs.
- `btn`, input, 32: raw asynchronous button inputs.
- `rdata`, output, 32: combinational read of the addressed register.

## Operation
Register map (word offsets):
- 0x00 SW: synchronised switches, read-only.
- 0x10 BTN: debounced button level, bit i = 1 when pressed, read-only.
- 0x14 BTN_EDGE: sticky press events, bit i set on each 0→1 transition of BTN[i]; write-1-to-clear.
- 0x18 BTN_CNT: 16-bit count of all press events summed over all buttons, saturating at 0xFFFF, in bits [15:0]. Any write clears it.
- Any other offset reads 0. Writes to read-only or unmapped offsets are ignored.

Synchronisation:
- `sw` and `btn` each pass through two flop stages.
- Inversion selected by `BTN_INV` is applied after the second stage.

Debounce, per button, with an independent counter of width `$clog2(DEB_CYCLES)`:
- Synchronised value ≠ stable level: the counter increments.
- Synchronised value = stable level: the counter clears to 0.
- Counter at `DEB_CYCLES-1` while the values still differ: the stable level takes the synchronised value and the counter clears.

Event logic:
- A rising edge is stable level = 1 while the previous-cycle stable level = 0.
- BTN_EDGE update: `edge_q <= (edge_q & ~(clr_mask)) | rise`, where `clr_mask = wdata[NBTN-1:0]` when `wren && addr==0x14`. When a set and a clear hit the same bit in the same cycle, set wins.
- BTN_CNT adds popcount(rise) per cycle and saturates at 0xFFFF.
- A write to BTN_CNT in the same cycle as a rise loads popcount(rise), not 0.

## Timing
- Reset: all synchroniser, stable, counter, edge and count flops are 0. `rdata` therefore reads 0 at every offset after reset.
- Reads are combinational from registered state: zero-wait, valid in the same cycle `addr` is presented.
- Switch latency: a raw `sw` value stable before edge k is visible in SW after edge k+1.
- Button latency: with debounce, BTN updates after edge k+1+DEB_CYCLES. BTN_EDGE and BTN_CNT reflect the press one edge later.
- Writes take effect at the clock edge where `wren` is sampled high.
- `rst` asserted mid-debounce aborts the count. The next stable level is 0 regardless of the raw input.
- A bounce (one cycle of equality) during the counting window restarts the count from 0.

## Configuration
- `IN_PERIPH_DEBOUNCE_EN` defined: the debounce counters are built and behave as in Operation.
- `IN_PERIPH_DEBOUNCE_EN` undefined: no counters are built. The stable level equals the synchronised (and optionally inverted) value, so BTN latency matches the SW latency. `DEB_CYCLES` is ignored.

## Structure
- Shared package `periph_pkg` holds:
  - register-offset localparams `IN_SW_OFS`, `IN_BTN_OFS`, `IN_EDGE_OFS`, `IN_CNT_OFS`;
  - the `IN_CNT_W = 16` constant;
  - a `sync2` width parameter default.
- One sub-module, `btn_debounce`: a single-button synchroniser-output-to-stable-level filter, instantiated `NBTN` times with a generate loop.
- Top level holds the synchronisers, edge detect, event registers and read mux.

## Test plan
All scenarios use `DEB_CYCLES=4`, `NBTN=4`.
- Reset: hold `rst` 3 cycles with `sw=32'hFFFF_FFFF`, `btn=4'hF` → reads at 0x00, 0x10, 0x14 and 0x18 all return 0 during reset.
- Switch latency: `sw=32'h0000_A5A5` → SW reads 0x0000A5A5 from the second edge onward; reads at 0x20 return 0.
- Clean press: hold `btn[2]=1` → BTN=0x4 after edge 2+4. On the next edge BTN_EDGE=0x4 and BTN_CNT=1.
- Bounce: `btn[0]` toggles 1,1,0,1,1,1,1 → BTN[0] rises only after 4 consecutive stable cycles following the 0; BTN_CNT increments by exactly 1.
- Clear race: write `wdata=0x4` to 0x14 in the same cycle a new `btn[2]` rise is registered → BTN_EDGE[2] stays 1. The same write without a rise → BTN_EDGE=0.
- Macro off: rebuild without `IN_PERIPH_DEBOUNCE_EN` and repeat the clean press → BTN=0x4 after 2 edges.
